// File: rtl/operand_loader_pkg.sv
// Shared definitions for the operand loader: state encoding and default sizes.
// Optional feature macro used by this slice: DEBOUNCE_EN (enter-button debounce).
package Pkg_Global;

  // Default operand width, matching the attached operand registers
  localparam int DEFAULT_N = 4;

  // Default number of cycles to wait for a loaded response
  localparam int DEFAULT_TIMEOUT = 16;

  // Default number of consecutive high samples needed on enter
  localparam int DEFAULT_DEBOUNCE_CYCLES = 8;

  // Loader sequencing states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    WAIT_A = 3'd2,
    ARM_B  = 3'd3,
    LOAD_B = 3'd4,
    WAIT_B = 3'd5,
    READY  = 3'd6,
    ERROR  = 3'd7
  } state_t;

endpackage

// File: rtl/operand_loader_button_edge.sv
// Push-button conditioning for the operand loader: optional debounce followed
// by a rising-edge detector. Debounce is compiled in only with DEBOUNCE_EN.
module button_edge
  import Pkg_Global::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic level_clean;
  logic level_q;

`ifdef DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DB_W-1:0] db_count;
  logic            stable;

  // Count consecutive high samples; the cleaned level rises only once a full
  // run has been seen, and any low sample drops it and restarts the run
  always_ff @(posedge clk) begin
    if (rst) begin
      db_count <= '0;
      stable   <= 1'b0;
    end else if (!level) begin
      db_count <= '0;
      stable   <= 1'b0;
    end else begin
      if (db_count != DB_W'(DEBOUNCE_CYCLES)) begin
        db_count <= db_count + 1'b1;
      end
      stable <= (db_count >= DB_W'(DEBOUNCE_CYCLES - 1));
    end
  end

  assign level_clean = stable;
`else
  assign level_clean = level;
`endif

  // Remember the previous cleaned level so a held button yields one edge
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_clean;
    end
  end

  assign rise = level_clean & ~level_q;

endmodule

// File: rtl/operand_loader.sv
// Operand loader: captures two operands from switches on successive enter
// presses, strobes them into the A and B registers and waits for each
// register to acknowledge, flagging a timeout if an acknowledge never comes.
// Optional feature macro: DEBOUNCE_EN (debounce on the enter button).
module operand_loader
  import Pkg_Global::*;
#(
  parameter int N               = DEFAULT_N,
  parameter int TIMEOUT         = DEFAULT_TIMEOUT,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enter,
  input  logic         clear,
  input  logic [N-1:0] in,
  input  logic         loaded_a,
  input  logic         loaded_b,
  output logic         load_a,
  output logic         load_b,
  output logic [N-1:0] operand_bus,
  output logic         ready,
  output logic         error,
  output logic         busy
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] wait_count;
  logic             enter_edge;

  button_edge #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_button_edge (
    .clk  (clk),
    .rst  (rst),
    .level(enter),
    .rise (enter_edge)
  );

  // Sequencer: every output is registered alongside the state it belongs to,
  // strobes default low so they last exactly one cycle, and the wait counter
  // defaults to zero so it restarts on every state entry
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      load_a      <= 1'b0;
      load_b      <= 1'b0;
      operand_bus <= '0;
      ready       <= 1'b0;
      error       <= 1'b0;
      busy        <= 1'b0;
      wait_count  <= '0;
    end else begin
      load_a     <= 1'b0;
      load_b     <= 1'b0;
      wait_count <= '0;
      if (clear) begin
        state <= IDLE;
        ready <= 1'b0;
        error <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (enter_edge) begin
              state       <= LOAD_A;
              operand_bus <= in;
              load_a      <= 1'b1;
              busy        <= 1'b1;
            end
          end
          LOAD_A: begin
            state <= WAIT_A;
          end
          WAIT_A: begin
            if (loaded_a) begin
              state <= ARM_B;
              busy  <= 1'b0;
            end else if (wait_count == CNT_LAST) begin
              state <= ERROR;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              wait_count <= (wait_count == CNT_MAX) ? wait_count : wait_count + 1'b1;
            end
          end
          ARM_B: begin
            if (enter_edge) begin
              state       <= LOAD_B;
              operand_bus <= in;
              load_b      <= 1'b1;
              busy        <= 1'b1;
            end
          end
          LOAD_B: begin
            state <= WAIT_B;
          end
          WAIT_B: begin
            if (loaded_b) begin
              state <= READY;
              busy  <= 1'b0;
              ready <= 1'b1;
            end else if (wait_count == CNT_LAST) begin
              state <= ERROR;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              wait_count <= (wait_count == CNT_MAX) ? wait_count : wait_count + 1'b1;
            end
          end
          READY: begin
            state <= READY;
          end
          ERROR: begin
            state <= ERROR;
          end
          default: begin
            state <= IDLE;
            ready <= 1'b0;
            error <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
